// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Two producers (A = EX result, B = MEM load) feed a one-entry output stage.
//
// Ports:
//   clk, rst          : clock, async active-high reset
//   a_valid/a_reg/a_data, a_ready : requester A handshake and payload
//   b_valid/b_reg/b_data, b_ready : requester B handshake and payload
//   wb_hold           : freeze; nothing accepted, no write issued
//   DstReg/WriteReg/DstData : register-file write port
//   busy              : one-hot pending write held in the output stage
//   conflict_cnt      : saturating count of accepts with both valid
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 16,
  parameter int CNT_W  = 16,
  localparam int REG_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              wb_hold,
  output logic [REG_W-1:0]  DstReg,
  output logic              WriteReg,
  output logic [DATA_W-1:0] DstData,
  output logic [REG_N-1:0]  busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              occ_q, occ_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  // last grant: 0 = A, 1 = B
  logic              lg_q, lg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept_ok;
  logic both;
  logic grant_a;
  logic grant_b;

  // The register file never stalls, so the stage drains in any
  // non-held cycle and may be refilled at the same edge.
  always_comb begin
    accept_ok = !wb_hold && !rst;
    both      = a_valid && b_valid;
    grant_a   = accept_ok && a_valid && (!b_valid || lg_q);
    grant_b   = accept_ok && b_valid && (!a_valid || !lg_q);
  end

  always_comb begin
    occ_d  = occ_q;
    reg_d  = reg_q;
    data_d = data_q;
    lg_d   = lg_q;
    cnt_d  = cnt_q;
    if (!wb_hold) begin
      occ_d = grant_a || grant_b;
      if (grant_a) begin
        reg_d  = a_reg;
        data_d = a_data;
        lg_d   = 1'b0;
      end else if (grant_b) begin
        reg_d  = b_reg;
        data_d = b_data;
        lg_d   = 1'b1;
      end
      if (both && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
      lg_q   <= 1'b1;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      reg_q  <= reg_d;
      data_q <= data_d;
      lg_q   <= lg_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    a_ready      = grant_a;
    b_ready      = grant_b;
    WriteReg     = occ_q && !wb_hold;
    DstReg       = reg_q;
    DstData      = data_q;
    conflict_cnt = cnt_q;
    busy         = '0;
    if (occ_q) begin
      busy[reg_q] = 1'b1;
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back arbiter for the 16x16 register file's single write port (DstReg/WriteReg/DstData).
- Shares the port between two producers: requester A (ALU/EX result) and requester B (load/MEM result).
- Uses round-robin arbitration with a valid/ready handshake and a one-entry registered output stage.
- Provides a pipeline-driven hold input, a pending-write busy vector for hazard logic, and a saturating conflict counter.

Parameters:
- DATA_W, 16, width of write data.
- REG_N, 16, number of architectural registers; register index width is log2(REG_N) = 4.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- a_valid  in  1  requester A has a write.
- a_reg  in  4  destination register of A.
- a_data  in  16  write data of A.
- a_ready  out  1  A accepted this cycle when a_valid & a_ready.
- b_valid  in  1  requester B has a write.
- b_reg  in  4  destination register of B.
- b_data  in  16  write data of B.
- b_ready  out  1  B accepted this cycle when b_valid & b_ready.
- wb_hold  in  1  freeze write-back; no accept, no write issued.
- DstReg  out  4  register-file write index.
- WriteReg  out  1  register-file write enable.
- DstData  out  16  register-file write data.
- busy  out  16  one-hot pending write: busy[i]=1 iff the output stage holds a write to register i.
- conflict_cnt  out  16  number of accept cycles in which both requesters were valid; saturates.

Behaviour:
- State: output stage (occ, reg, data); last-grant pointer lg (0=A, 1=B); conflict_cnt.
- Reset, asynchronous, any time including mid-transfer:
  - occ=0, reg=0, data=0, lg=1, conflict_cnt=0.
  - Outputs: WriteReg=0, DstReg=0, DstData=0, busy=0, a_ready=b_ready=0 while rst is high.
  - Any in-flight entry is discarded.
- Accept window: accept_ok = !wb_hold. The register file never back-pressures, so an occupied stage drains in any non-held cycle and can be refilled in the same cycle.
- Grant (combinational, only when accept_ok):
  - only a_valid → a_ready=1.
  - only b_valid → b_ready=1.
  - both valid → grant A if lg=1, grant B if lg=0. The loser's ready=0 and it must hold its valid and payload stable.
  - neither valid → both ready=0.
  - Ready never depends on the requester's own valid in a way that forms a loop; ready is a function of both valids, lg and wb_hold.
- On rising edge with a grant:
  - Stage loads the winner's reg/data; occ=1; lg=winner.
  - conflict_cnt increments if both were valid; it holds at all-ones (0xFFFF) once reached.
- On rising edge, not held, no grant: occ=0.
- On rising edge while held: stage, lg and conflict_cnt unchanged.
- Outputs:
  - WriteReg = occ & !wb_hold.
  - DstReg/DstData = stage contents; they remain stable while held.
  - busy = occ ? onehot(reg) : 0. busy stays asserted while held.
- Latency: accept at edge N → WriteReg high during cycle N..N+1 → register file writes at edge N+1. Same-cycle readers see the data through the register file's bypass.
- Back-to-back: one write per cycle sustained. Two simultaneous requests complete in two consecutive cycles.
- Same destination from both requesters: no merging; both writes issue in grant order, and the later grant's data is final.
- wb_hold asserted while the stage is occupied: write is withheld. On the first non-held cycle WriteReg=1 with the original contents, and a new grant may load at that same edge.
- Register 0 has no special treatment.

Test Plan:
- Reset mid-operation:
  - Stimulus: a_valid=1, a_reg=3, a_data=0x1234, then assert rst asynchronously before the next edge.
  - Required: WriteReg=0, busy=0, conflict_cnt=0 immediately; after release the first conflict grants A.
- Single requester:
  - Stimulus: b_valid=1, b_reg=7, b_data=0xBEEF for one cycle.
  - Required: b_ready=1; next cycle WriteReg=1, DstReg=7, DstData=0xBEEF, busy=0x0080; following cycle WriteReg=0.
- Round-robin:
  - Stimulus: both valid for 4 cycles with A=(2,0x0A0A) and B=(5,0x0B0B); the winner drops and re-presents a new payload after each win.
  - Required: grants A,B,A,B; conflict_cnt=4; WriteReg continuous for 4 cycles.
- Hold:
  - Stimulus: accept A (reg 9, 0x5555), then wb_hold=1 for 3 cycles with b_valid=1.
  - Required: WriteReg=0, busy=0x0200, b_ready=0 throughout. On release: WriteReg=1 with DstReg=9/0x5555 and b_ready=1 in the same cycle; B is written the next cycle.
- Same-register collision:
  - Stimulus: A=(4,0x1111) and B=(4,0x2222) both valid with lg=0.
  - Required: B written first, then A; the final value of R4 is 0x1111.
- Saturation:
  - Stimulus: force 65537 conflict accepts.
  - Required: conflict_cnt=0xFFFF and it stays there.
